// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath and
// pipeline_hazard_ctrl.
//   master : the hazard controller. It reads the hazard sources and drives the
//            stage enables, flushes, dmem request, error flag and counters.
//   slave  : the pipeline datapath. It drives the hazard sources and consumes
//            the controls.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CW = 16
);
  // Hazard sources from the pipeline
  logic [4:0]    id_rs1;
  logic [4:0]    id_rs2;
  logic          id_uses_rs2;
  logic          id_ex_memread;
  logic [4:0]    id_ex_rd;
  logic          ex_mem_memacc;
  logic          branch_taken;
  logic          dmem_ready;
  // Controls back to the pipeline
  logic          dmem_req;
  logic          pc_write;
  logic          if_id_write;
  logic          id_ex_write;
  logic          ex_mem_write;
  logic          if_id_flush;
  logic          id_ex_flush;
  logic          ex_mem_flush;
  logic          mem_wb_bubble;
  logic          mem_err;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  modport master (
    input  id_rs1, id_rs2, id_uses_rs2, id_ex_memread, id_ex_rd,
    input  ex_mem_memacc, branch_taken, dmem_ready,
    output dmem_req, pc_write, if_id_write, id_ex_write, ex_mem_write,
    output if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble,
    output mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    output id_rs1, id_rs2, id_uses_rs2, id_ex_memread, id_ex_rd,
    output ex_mem_memacc, branch_taken, dmem_ready,
    input  dmem_req, pc_write, if_id_write, id_ex_write, ex_mem_write,
    input  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble,
    input  mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage RISC-V pipeline.
// The controller resolves three hazards in priority order:
//   1. Freeze: a data memory access is outstanding. The whole pipeline holds
//      and MEM_WB takes a bubble.
//   2. Branch flush: a branch resolved taken in MEM. The PC loads the target
//      and IF_ID, ID_EX and EX_MEM are squashed.
//   3. Load-use: the instruction in ID needs the result of a load in EX. PC and
//      IF_ID hold and a bubble goes into ID_EX.
// The controller also keeps saturating stall and flush counters and a sticky
// memory-timeout flag.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : hazard sources in, stage controls and status out
//           (see pipeline_hazard_ctrl_if)
module pipeline_hazard_ctrl #(
  parameter int unsigned CW      = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.master bus
);

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StMemWait = 2'd1;
  localparam logic [1:0] StErr     = 2'd2;

  localparam logic [7:0]    TimeoutVal = 8'(TIMEOUT);
  localparam logic [CW-1:0] CntMax     = {CW{1'b1}};

  logic [1:0]    state_q, state_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CW-1:0] flush_cnt_q, flush_cnt_d;
  logic          mem_err_q, mem_err_d;

  logic freeze;
  logic branch_flush;
  logic load_use;
  logic raw_dep;

  // Hazard decode
  always_comb begin
    freeze = ((state_q == StRun) && bus.ex_mem_memacc && !bus.dmem_ready) ||
             ((state_q == StMemWait) && !bus.dmem_ready) ||
             (state_q == StErr);
    raw_dep = (bus.id_ex_rd == bus.id_rs1) ||
              (bus.id_uses_rs2 && (bus.id_ex_rd == bus.id_rs2));
    branch_flush = !freeze && bus.branch_taken;
    // The dependent instruction is squashed by a taken branch, so no stall then.
    load_use = !freeze && !bus.branch_taken && bus.id_ex_memread &&
               (bus.id_ex_rd != 5'd0) && raw_dep;
  end

  // Stage controls. Reset gates them directly so they reach their safe values
  // without waiting for a clock edge.
  always_comb begin
    bus.pc_write      = 1'b1;
    bus.if_id_write   = 1'b1;
    bus.id_ex_write   = 1'b1;
    bus.ex_mem_write  = 1'b1;
    bus.if_id_flush   = 1'b0;
    bus.id_ex_flush   = 1'b0;
    bus.ex_mem_flush  = 1'b0;
    bus.mem_wb_bubble = 1'b0;
    bus.dmem_req      = 1'b0;

    if (!reset) begin
      bus.pc_write      = 1'b0;
      bus.if_id_write   = 1'b0;
      bus.id_ex_write   = 1'b0;
      bus.ex_mem_write  = 1'b0;
      bus.mem_wb_bubble = 1'b1;
    end else begin
      case (state_q)
        StRun:     bus.dmem_req = bus.ex_mem_memacc;
        StMemWait: bus.dmem_req = 1'b1;
        default:   bus.dmem_req = 1'b0;
      endcase

      if (freeze) begin
        bus.pc_write      = 1'b0;
        bus.if_id_write   = 1'b0;
        bus.id_ex_write   = 1'b0;
        bus.ex_mem_write  = 1'b0;
        bus.mem_wb_bubble = 1'b1;
      end else if (branch_flush) begin
        bus.if_id_flush  = 1'b1;
        bus.id_ex_flush  = 1'b1;
        bus.ex_mem_flush = 1'b1;
      end else if (load_use) begin
        bus.pc_write    = 1'b0;
        bus.if_id_write = 1'b0;
        bus.id_ex_flush = 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    case (state_q)
      StRun: begin
        if (bus.ex_mem_memacc && !bus.dmem_ready) begin
          state_d    = StMemWait;
          wait_cnt_d = 8'd1;
        end
      end
      StMemWait: begin
        if (bus.dmem_ready) begin
          state_d    = StRun;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == TimeoutVal) begin
          state_d   = StErr;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      StErr: state_d = StErr;
      default: state_d = StRun;
    endcase

    if ((freeze || load_use) && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + CW'(1);
    end
    if (branch_flush && (flush_cnt_q != CntMax)) begin
      flush_cnt_d = flush_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StRun;
      wait_cnt_q  <= 8'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
  assign bus.mem_err   = mem_err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl, built with CW=4 and TIMEOUT=4.
module tb_pipeline_hazard_ctrl;

  // Control vector bit order:
  // {pc_write, if_id_write, id_ex_write, ex_mem_write,
  //  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble, dmem_req}
  localparam logic [15:0] CtlIdle   = 16'b0000000_1111_000_0_0;
  localparam logic [15:0] CtlAdv    = 16'b0000000_1111_000_0_1;
  localparam logic [15:0] CtlFrzReq = 16'b0000000_0000_000_1_1;
  localparam logic [15:0] CtlFrzErr = 16'b0000000_0000_000_1_0;
  localparam logic [15:0] CtlReset  = 16'b0000000_0000_000_1_0;
  localparam logic [15:0] CtlBranch = 16'b0000000_1111_111_0_0;
  localparam logic [15:0] CtlLdUse  = 16'b0000000_0011_010_0_0;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  pipeline_hazard_ctrl_if #(.CW(4)) bus ();

  pipeline_hazard_ctrl #(
    .CW     (4),
    .TIMEOUT(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] ctl();
    return {7'd0, bus.pc_write, bus.if_id_write, bus.id_ex_write, bus.ex_mem_write,
            bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.mem_wb_bubble,
            bus.dmem_req};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.id_rs1        = 5'd0;
    bus.id_rs2        = 5'd0;
    bus.id_uses_rs2   = 1'b0;
    bus.id_ex_memread = 1'b0;
    bus.id_ex_rd      = 5'd0;
    bus.ex_mem_memacc = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.dmem_ready    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    idle();
    #3;
    check("reset_ctl", ctl(), CtlReset);
    check("reset_stall", 16'(bus.stall_cnt), 16'd0);
    check("reset_flush", 16'(bus.flush_cnt), 16'd0);
    check("reset_err", 16'(bus.mem_err), 16'd0);

    @(negedge clk);
    reset = 1'b1;
    #1;
    check("run_idle", ctl(), CtlIdle);

    // Load-use on rs1
    bus.id_ex_memread = 1'b1;
    bus.id_ex_rd      = 5'd5;
    bus.id_rs1        = 5'd5;
    #1;
    check("ldu_rs1_ctl", ctl(), CtlLdUse);
    tick();
    check("ldu_rs1_stall", 16'(bus.stall_cnt), 16'd1);
    bus.id_ex_memread = 1'b0;
    #1;
    check("ldu_release", ctl(), CtlIdle);

    // rd = x0 never stalls
    bus.id_ex_memread = 1'b1;
    bus.id_ex_rd      = 5'd0;
    bus.id_rs1        = 5'd0;
    #1;
    check("ldu_x0_ctl", ctl(), CtlIdle);
    tick();
    check("ldu_x0_stall", 16'(bus.stall_cnt), 16'd1);

    // rs2 match only counts when rs2 is used
    bus.id_ex_rd    = 5'd5;
    bus.id_rs1      = 5'd3;
    bus.id_rs2      = 5'd5;
    bus.id_uses_rs2 = 1'b0;
    #1;
    check("ldu_rs2_unused", ctl(), CtlIdle);
    bus.id_uses_rs2 = 1'b1;
    #1;
    check("ldu_rs2_used", ctl(), CtlLdUse);
    tick();
    check("ldu_rs2_stall", 16'(bus.stall_cnt), 16'd2);
    idle();

    // Taken branch
    bus.branch_taken = 1'b1;
    #1;
    check("br_ctl", ctl(), CtlBranch);
    tick();
    check("br_flush_cnt", 16'(bus.flush_cnt), 16'd1);

    // Taken branch with a simultaneous load-use hazard
    bus.id_ex_memread = 1'b1;
    bus.id_ex_rd      = 5'd5;
    bus.id_rs1        = 5'd5;
    #1;
    check("br_ldu_ctl", ctl(), CtlBranch);
    tick();
    check("br_ldu_stall", 16'(bus.stall_cnt), 16'd2);
    check("br_ldu_flush", 16'(bus.flush_cnt), 16'd2);
    idle();

    // Memory access with 3 wait cycles
    bus.ex_mem_memacc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("mw_freeze%0d", i), ctl(), CtlFrzReq);
      tick();
    end
    bus.dmem_ready = 1'b1;
    #1;
    check("mw_advance", ctl(), CtlAdv);
    tick();
    check("mw_stall", 16'(bus.stall_cnt), 16'd5);
    bus.ex_mem_memacc = 1'b0;
    bus.dmem_ready    = 1'b0;
    #1;
    check("mw_back_run", ctl(), CtlIdle);

    // Zero-wait access
    bus.ex_mem_memacc = 1'b1;
    bus.dmem_ready    = 1'b1;
    #1;
    check("zw_ctl", ctl(), CtlAdv);
    tick();
    check("zw_stall", 16'(bus.stall_cnt), 16'd5);

    // Timeout: 1 RUN freeze cycle plus 4 MEM_WAIT cycles, then ERR
    bus.dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("to_pre_ctl", ctl(), CtlFrzReq);
    check("to_pre_err", 16'(bus.mem_err), 16'd0);
    tick();
    check("to_err", 16'(bus.mem_err), 16'd1);
    check("to_err_ctl", ctl(), CtlFrzErr);
    check("to_stall", 16'(bus.stall_cnt), 16'd10);
    bus.ex_mem_memacc = 1'b0;
    bus.dmem_ready    = 1'b1;
    tick();
    check("to_err_hold", ctl(), CtlFrzErr);
    check("to_stall_hold", 16'(bus.stall_cnt), 16'd11);
    #2;
    reset = 1'b0;
    #1;
    check("to_rst_err", 16'(bus.mem_err), 16'd0);
    check("to_rst_ctl", ctl(), CtlReset);
    idle();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("to_rst_run", ctl(), CtlIdle);

    // Reset during the 2nd MEM_WAIT cycle
    bus.ex_mem_memacc = 1'b1;
    tick();
    tick();
    check("mid_mw_ctl", ctl(), CtlFrzReq);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_ctl", ctl(), CtlReset);
    @(negedge clk);
    idle();
    reset = 1'b1;
    #1;
    check("mid_rel_stall", 16'(bus.stall_cnt), 16'd0);
    check("mid_rel_flush", 16'(bus.flush_cnt), 16'd0);
    check("mid_rel_ctl", ctl(), CtlIdle);

    // Saturation: 20 load-use cycles on a 4-bit counter
    bus.id_ex_memread = 1'b1;
    bus.id_ex_rd      = 5'd7;
    bus.id_rs1        = 5'd7;
    for (int i = 0; i < 20; i++) tick();
    check("sat_stall", 16'(bus.stall_cnt), 16'd15);
    check("sat_ctl", ctl(), CtlLdUse);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and sequencing controller for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB). It detects load-use hazards and inserts a bubble. It squashes the three younger instructions when a branch resolves taken in MEM. It freezes the whole pipeline while a multi-cycle data memory access is outstanding, and flags a memory timeout. It drives the write-enable and flush controls of the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers, and keeps saturating stall and flush performance counters.

## Interface
- CW, 16, width of the performance counters
- TIMEOUT, 15, maximum MEM_WAIT cycles before error (1..255)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_uses_rs2  in  1  ID instruction reads rs2 (R-type, store, branch)
- id_ex_memread  in  1  instruction in EX is a load
- id_ex_rd  in  5  destination of the instruction in EX
- ex_mem_memacc  in  1  instruction in MEM is a load or store
- branch_taken  in  1  Branch_Control PC-select from the MEM stage
- dmem_ready  in  1  data memory completes the current access this cycle
- dmem_req  out  1  data memory access request
- pc_write  out  1  PC load enable
- if_id_write, id_ex_write, ex_mem_write  out  1 each  pipeline register load enables
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a bubble (all control bits 0) on this edge
- mem_wb_bubble  out  1  MEM_WB loads RegWrite=0, MemtoReg=0
- mem_err  out  1  sticky memory-timeout flag
- stall_cnt  out  CW  stall cycles, saturating
- flush_cnt  out  CW  taken-branch flush events, saturating

## Operation
- FSM states: RUN, MEM_WAIT, ERR. The state register, wait_cnt, the counters and mem_err are the only flops. All other outputs are combinational from the state and the inputs.
- Default (RUN, no hazard): all write enables 1, all flushes 0, mem_wb_bubble 0.
- Conditions are evaluated in priority order; the highest active condition wins.
- Freeze has top priority.
  - Condition: (RUN and ex_mem_memacc and !dmem_ready), or (MEM_WAIT and !dmem_ready), or ERR.
  - Action: pc_write, if_id_write, id_ex_write and ex_mem_write are 0, all flushes are 0, mem_wb_bubble is 1.
- Branch flush is second. Condition: branch_taken and no freeze.
  - pc_write is 1, so the PC loads the branch target.
  - if_id_flush, id_ex_flush and ex_mem_flush are 1.
  - flush_cnt increments.
- Load-use stall is third.
  - Condition: id_ex_memread and id_ex_rd≠0 and (id_ex_rd==id_rs1 or (id_uses_rs2 and id_ex_rd==id_rs2)).
  - Action: pc_write and if_id_write are 0, id_ex_flush is 1, ex_mem_write is 1.
  - A branch flush suppresses the load-use stall, because the dependent instruction is squashed.
- stall_cnt increments in every freeze or load-use cycle. Both counters hold at 2^CW−1.
- dmem_req = ex_mem_memacc in RUN; 1 in MEM_WAIT; 0 in ERR.
- Transitions:
  - RUN → MEM_WAIT when ex_mem_memacc and !dmem_ready. wait_cnt is set to 1.
  - MEM_WAIT → RUN on dmem_ready. That cycle is unfrozen and the pipeline advances.
  - MEM_WAIT with !dmem_ready and wait_cnt==TIMEOUT → ERR, and mem_err is set.
  - Otherwise MEM_WAIT stays and wait_cnt increments.
  - ERR is held until reset.
- The width of wait_cnt is 8 bits.

## Timing
- Reset (async, reset=0):
  - State RUN, wait_cnt 0, stall_cnt 0, flush_cnt 0, mem_err 0.
  - While reset is low: all write enables 0, all flushes 0, mem_wb_bubble 1, dmem_req 0.
- An access with zero wait (dmem_ready in the same cycle as the request) costs no stall cycles.
- An access with N wait cycles (ready in cycle N after the request) costs N frozen cycles; stall_cnt increases by N.
- A load-use hazard costs exactly 1 bubble. The next cycle, id_ex_memread is 0, so the stall releases naturally.
- A taken branch costs 3 squashed slots and 1 flush cycle. The PC holds the target on the following edge.
- dmem_req stays asserted from the first request cycle until the dmem_ready cycle. The EX_MEM contents are stable throughout.
- Simultaneous events:
  - Freeze masks branch_taken. This cannot occur legally, because a branch does not access memory.
  - Load-use detected during a freeze is re-evaluated after the freeze ends.
- Reset low during MEM_WAIT returns to RUN immediately and drops dmem_req asynchronously.

## Test plan
- Load-use stall:
  - Stimulus: id_ex_memread=1, id_ex_rd=5, id_rs1=5.
  - Required: pc_write=0, if_id_write=0, id_ex_flush=1 for one cycle; stall_cnt 0→1.
  - Repeat with id_ex_rd=0: no stall.
  - Repeat with id_rs2=5 and id_uses_rs2=0: no stall.
- Taken branch:
  - Stimulus: branch_taken=1 for one cycle.
  - Required: all three flushes 1 and pc_write=1; flush_cnt 0→1.
  - With a simultaneous load-use hazard: no stall, stall_cnt unchanged.
- Memory wait:
  - Stimulus: ex_mem_memacc=1, dmem_ready low for 3 cycles, then high.
  - Required: dmem_req=1 for all 4 cycles; freeze and mem_wb_bubble=1 for 3 cycles; advance in cycle 4; stall_cnt=3; state back to RUN.
- Timeout:
  - Stimulus: TIMEOUT=4, dmem_ready never asserted.
  - Required: ERR after 4 wait cycles, mem_err=1, dmem_req=0, freeze held.
  - Asserting reset clears ERR to RUN and mem_err to 0.
- Reset mid-operation:
  - Stimulus: drop reset in the 2nd MEM_WAIT cycle.
  - Required: outputs go to their reset values without waiting for a clock edge; the counters read 0 after release.
- Saturation:
  - Stimulus: CW=4, 20 load-use cycles.
  - Required: stall_cnt holds at 15.
